unary_sum_collect: RTL and testbench

Downstream stage of the 3-bit unary adder. It consumes the adder's serial unary output (`dout`) and its overflow flag (`C`), and counts the contiguous run of ones emitted during each write phase. Each run becomes one binary result, held on a valid/ready handshake together with a sticky overflow bit. It converts the adder's thermometer-style stream back into binary for the rest of the datapath.

---
 rtl/unary_pkg.sv | 18 +
 rtl/unary_run_counter.sv | 44 ++++
 rtl/unary_sum_collect.sv | 162 ++++++++++++++++
 tb/tb_unary_sum_collect.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary adder datapath: collector FSM states,
// default accumulator width and the longest representable run.
package unary_pkg;

  localparam int UNARY_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } collect_state_t;

  // Longest run of ones a WIDTH-bit result can hold.
  function automatic int max_run(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/unary_run_counter.sv
// Saturating run-length counter for the unary collector.
// clr has priority over load1, which has priority over inc.
module unary_run_counter
  import unary_pkg::*;
#(
  parameter int WIDTH = UNARY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(max_run(WIDTH));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, start a run at one, or step up and stick at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = WIDTH'(1);
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/unary_sum_collect.sv
// unary_sum_collect: turns the unary adder's serial write-phase output back
// into a binary run length, presented on a valid/ready handshake with a
// sticky per-frame overflow bit.
// Optional build macro UNARY_COLLECT_ERR_EN adds the sticky err_fmt output
// flagging non-contiguous runs and runs longer than the result can hold.
module unary_sum_collect
  import unary_pkg::*;
#(
  parameter int WIDTH = UNARY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             read_or_write,
  input  logic             din,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             drop
`ifdef UNARY_COLLECT_ERR_EN
  ,
  output logic             err_fmt
`endif
);

  collect_state_t   state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic             ph_d_q, ph_d_d;      // phase delayed to line up with din
  logic             armed_q, armed_d;    // one frame allowed per write phase
  logic             ovf_acc_q, ovf_acc_d;
  logic             cnt_load, cnt_inc, cnt_clr, capture;
  logic [WIDTH-1:0] cnt;

  unary_run_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (cnt)
  );

  // Phase alignment, arming, overflow accumulation and the collect FSM.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    drop_d    = 1'b0;
    ph_d_d    = ph_d_q;
    armed_d   = armed_q;
    ovf_acc_d = ovf_acc_q;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    capture   = 1'b0;

    if (en) begin
      ph_d_d = read_or_write;
      if (!ph_d_q) armed_d = 1'b1;
      if (c_in && (state_q != DONE)) ovf_acc_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en && ph_d_q && armed_q) begin
          armed_d = 1'b0;
          if (din) begin
            cnt_load = 1'b1;
            state_d  = RUN;
          end else begin
            // Write phase opened with a zero: empty frame.
            sum_d   = '0;
            capture = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (en) begin
          if (din && ph_d_q) begin
            cnt_inc = 1'b1;
          end else begin
            sum_d   = cnt;
            capture = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (sum_ready) state_d = IDLE;
        // A new write frame while the result is still held is discarded.
        if (en && ph_d_q && armed_q) begin
          drop_d  = 1'b1;
          armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture hands the accumulated overflow to the result and restarts it.
    if (capture) begin
      ovf_d     = ovf_acc_q | (en & c_in);
      ovf_acc_d = 1'b0;
      cnt_clr   = 1'b1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      ph_d_q    <= 1'b0;
      armed_q   <= 1'b1;
      ovf_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      ph_d_q    <= ph_d_d;
      armed_q   <= armed_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end

  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign sum_valid = (state_q == DONE);
  assign drop      = drop_q;

`ifdef UNARY_COLLECT_ERR_EN
  localparam logic [WIDTH-1:0] RUN_MAX = WIDTH'(max_run(WIDTH));

  logic err_q, err_d;

  // Sticky format error: stray one outside a run, or a run past saturation.
  always_comb begin
    err_d = err_q;
    if (en && din && ph_d_q && !armed_q && (state_q != RUN)) err_d = 1'b1;
    if (en && din && (state_q == RUN) && (cnt == RUN_MAX))   err_d = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_fmt = err_q;
`endif

endmodule

// File: tb/tb_unary_sum_collect.sv
// Scoreboard bench for unary_sum_collect: stimulus tasks push the expected
// {sum, ovf} of each frame; a negedge monitor pops and compares on handshake.
module tb_unary_sum_collect;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         read_or_write;
  logic         din;
  logic         c_in;
  logic [W-1:0] sum;
  logic         ovf;
  logic         sum_valid;
  logic         sum_ready;
  logic         drop;
`ifdef UNARY_COLLECT_ERR_EN
  logic         err_fmt;
`endif

  int n_checks  = 0;
  int n_errors  = 0;
  int n_results = 0;
  int n_pushed  = 0;
  int drop_cnt  = 0;
  int exp_sum_q[$];
  int exp_ovf_q[$];

  unary_sum_collect #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .read_or_write (read_or_write),
    .din           (din),
    .c_in          (c_in),
    .sum           (sum),
    .ovf           (ovf),
    .sum_valid     (sum_valid),
    .sum_ready     (sum_ready),
    .drop          (drop)
`ifdef UNARY_COLLECT_ERR_EN
    ,
    .err_fmt       (err_fmt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int s, input int o);
    exp_sum_q.push_back(s);
    exp_ovf_q.push_back(o);
    n_pushed++;
  endtask

  // One clock with the given inputs; returns just after the rising edge.
  task automatic cyc(input logic e, input logic rw, input logic d, input logic c);
    en = e; read_or_write = rw; din = d; c_in = c;
    @(posedge clk);
    #1;
  endtask

  // k read cycles, optionally with a carry pulse in the second one.
  task automatic rd(input int k, input bit cpulse);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 1'b0, (cpulse && i == 1));
  endtask

  // Write phase of len cycles; upstream dout lags so ones occupy cycles 1..ones.
  task automatic wr(input int ones, input int len);
    for (int j = 0; j < len; j++) cyc(1'b1, 1'b1, (j >= 1 && j <= ones), 1'b0);
  endtask

  // Scoreboard monitor: compare each accepted result, count drop pulses.
  always @(negedge clk) begin
    if (drop) drop_cnt++;
    if (!rst && sum_valid && sum_ready) begin
      if (exp_sum_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("sum", int'(sum), exp_sum_q.pop_front());
        chk("ovf", int'(ovf), exp_ovf_q.pop_front());
        n_results++;
      end
    end
  end

  initial begin
    rst = 1'b1; sum_ready = 1'b1;
    en = 1'b0; read_or_write = 1'b0; din = 1'b0; c_in = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_valid", int'(sum_valid), 0);
    chk("rst_drop", int'(drop), 0);
`ifdef UNARY_COLLECT_ERR_EN
    chk("rst_err", int'(err_fmt), 0);
`endif
    rst = 1'b0;

    // 2+3: five ones, valid two cycles after the last one, cleared on accept.
    rd(2, 0);
    push_exp(5, 0);
    for (int j = 0; j < 7; j++) begin
      cyc(1, 1, (j >= 1 && j <= 5), 0);
      if (j == 5) chk("vld_early", int'(sum_valid), 0);
    end
    chk("vld_rise", int'(sum_valid), 1);
    chk("sum_at_rise", int'(sum), 5);
    cyc(1, 0, 0, 0);
    chk("vld_fall", int'(sum_valid), 0);
    rd(1, 0);

    // Carry out of the accumulator, then an empty write frame.
    rd(3, 1);
    push_exp(0, 1);
    wr(0, 3);
    rd(2, 0);

    // Write phase with no ones: exactly one empty result.
    push_exp(0, 0);
    wr(0, 5);
    rd(2, 0);
    chk("empty_once", n_results, 3);

    // Back-to-back write phases separated by a single read cycle.
    push_exp(2, 0);
    wr(2, 4);
    rd(1, 0);
    push_exp(1, 0);
    wr(1, 3);
    rd(2, 0);
    chk("b2b_results", n_results, 5);

    // Consumer stalls across a full read+write cycle: one drop, result held.
    sum_ready = 1'b0;
    push_exp(2, 0);
    wr(2, 4);
    rd(2, 0);
    wr(3, 5);
    chk("drop_hold_sum", int'(sum), 2);
    chk("drop_hold_vld", int'(sum_valid), 1);
    chk("drop_cnt", drop_cnt, 1);
    sum_ready = 1'b1;
    rd(2, 0);
    chk("drop_accepted", int'(sum_valid), 0);

    // en low for three cycles in the middle of a 4-one run.
    push_exp(4, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    rd(2, 0);

    // Nine ones saturate at 7; carry in the read phase gives ovf.
    rd(3, 1);
    push_exp(7, 1);
    wr(9, 11);
    rd(2, 0);

    // Reset in the middle of a run drops the partial count.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    rst = 1'b1;
    cyc(1, 0, 0, 0);
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_vld", int'(sum_valid), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      chk("midrst_no_vld", int'(sum_valid), 0);
    end

`ifdef UNARY_COLLECT_ERR_EN
    // Pattern 1,1,0,1 in one write phase: result 2, sticky format error.
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("err_clear", int'(err_fmt), 0);
    rd(2, 0);
    push_exp(2, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    chk("err_set", int'(err_fmt), 1);
    rd(3, 0);
    chk("err_sticky", int'(err_fmt), 1);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("err_rst", int'(err_fmt), 0);
`endif

    chk("sb_empty", exp_sum_q.size(), 0);
    chk("result_count", n_results, n_pushed);
    chk("drop_total", drop_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
